// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: square / duty / pulse waveform plus period tick.
// Optional phase-restart input sync_in is enabled by defining CLKDIV_SYNC_EN.
module clk_div_prog #(
  parameter int WIDTH        = 30,
  parameter int DEFAULT_DIV  = 20,
  parameter int DEFAULT_MODE = 0
) (
  input  logic             clock,
  input  logic             reset,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_in,
`endif
  input  logic             enable,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             out_clk,
  output logic             tick
);

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(2)) ? WIDTH'(2) : d;
  endfunction

  // d must already be clamped to >= 2
  function automatic logic [WIDTH-1:0] derive_high(input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] h,
                                                   input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    case (m)
      2'b01: begin
        r = (h == '0) ? WIDTH'(1) : h;
        if (r > d - WIDTH'(1)) r = d - WIDTH'(1);
      end
      2'b10:   r = WIDTH'(1);
      default: r = d >> 1;
    endcase
    return r;
  endfunction

  localparam logic [WIDTH-1:0] DEF_D = clamp_div(WIDTH'(DEFAULT_DIV));
  localparam logic [WIDTH-1:0] DEF_H = derive_high(DEF_D, '0, 2'(DEFAULT_MODE));

  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] high_reg, high_next;
  logic             running_reg, running_next;
  logic             pend_reg, pend_next;
  logic [WIDTH-1:0] sh_div_reg, sh_high_reg;
  logic [1:0]       sh_mode_reg;
  logic             out_clk_reg, out_clk_next;
  logic             tick_reg, tick_next;
  logic             apply;
  logic             sync_hit;
  logic             xfer;
  logic [WIDTH-1:0] sh_div_clamped;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync_in;
`else
  assign sync_hit = 1'b0;
`endif

  assign xfer           = cfg_valid && !pend_reg;
  assign sh_div_clamped = clamp_div(sh_div_reg);

  always_comb begin
    count_next   = count_reg;
    running_next = running_reg;
    div_next     = div_reg;
    high_next    = high_reg;
    pend_next    = pend_reg;
    apply        = 1'b0;

    // Every path that lands on C=0 is a period boundary where shadow config may load.
    if (!enable) begin
      running_next = 1'b0;
      count_next   = '0;
      apply        = pend_reg;
    end else if (!running_reg) begin
      running_next = 1'b1;
      count_next   = '0;
      apply        = pend_reg;
    end else if (sync_hit || (count_reg >= div_reg - WIDTH'(1))) begin
      count_next   = '0;
      apply        = pend_reg;
    end else begin
      count_next   = count_reg + WIDTH'(1);
    end

    if (apply) begin
      div_next  = sh_div_clamped;
      high_next = derive_high(sh_div_clamped, sh_high_reg, sh_mode_reg);
      pend_next = 1'b0;
    end
    if (xfer) pend_next = 1'b1;

    out_clk_next = running_next && (count_next < high_next);
    tick_next    = running_next && (count_next == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg   <= '0;
      running_reg <= 1'b0;
      div_reg     <= DEF_D;
      high_reg    <= DEF_H;
      pend_reg    <= 1'b0;
      sh_div_reg  <= '0;
      sh_high_reg <= '0;
      sh_mode_reg <= '0;
      out_clk_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      count_reg   <= count_next;
      running_reg <= running_next;
      div_reg     <= div_next;
      high_reg    <= high_next;
      pend_reg    <= pend_next;
      out_clk_reg <= out_clk_next;
      tick_reg    <= tick_next;
      if (xfer) begin
        sh_div_reg  <= cfg_div;
        sh_high_reg <= cfg_high;
        sh_mode_reg <= cfg_mode;
      end
    end
  end

  assign cfg_ready = !pend_reg;
  assign out_clk   = out_clk_reg;
  assign tick      = tick_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: an integer period model predicts each cycle's
// outputs into a queue; an independent monitor pops and compares after every edge.
module tb_clk_div_prog;
  localparam int W = 30;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] cfg_div;
  logic [W-1:0] cfg_high;
  logic [1:0]   cfg_mode;
  logic         cfg_valid;
  logic         cfg_ready;
  logic         out_clk;
  logic         tick;
`ifdef CLKDIV_SYNC_EN
  logic         sync_in;
`endif

  always #5 clock = ~clock;

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(20), .DEFAULT_MODE(0)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef CLKDIV_SYNC_EN
    .sync_in   (sync_in),
`endif
    .enable    (enable),
    .cfg_div   (cfg_div),
    .cfg_high  (cfg_high),
    .cfg_mode  (cfg_mode),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .out_clk   (out_clk),
    .tick      (tick)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_cyc = 0;
  bit         started = 1'b0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;

  // Reference: position within the current period plus the active period/high time.
  int m_ph, m_D, m_H, s_div, s_high, s_mode;
  bit m_run, m_pend;

  function automatic int eff_div(int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int eff_high(int d, int h, int m);
    int hh;
    if (m == 1) begin
      hh = (h < 1) ? 1 : h;
      return (hh > d - 1) ? d - 1 : hh;
    end
    if (m == 2) return 1;
    return d / 2;
  endfunction

  task automatic model_step();
    bit xfer, boundary, sy;
    sy = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sy = sync_in;
`endif
    if (reset) begin
      m_ph = 0; m_run = 0; m_pend = 0;
      m_D = 20; m_H = eff_high(20, 0, 0);
    end else begin
      xfer = cfg_valid && !m_pend;
      boundary = 1'b1;
      if (!enable) begin
        m_run = 0; m_ph = 0;
      end else if (!m_run) begin
        m_run = 1; m_ph = 0;
      end else if (sy || m_ph == m_D - 1) begin
        m_ph = 0;
      end else begin
        m_ph++; boundary = 1'b0;
      end
      if (boundary && m_pend) begin
        m_D = eff_div(s_div);
        m_H = eff_high(m_D, s_high, s_mode);
        m_pend = 0;
      end
      if (xfer) begin
        m_pend = 1;
        s_div = int'(cfg_div); s_high = int'(cfg_high); s_mode = int'(cfg_mode);
      end
    end
    exp_q.push_back({m_run && (m_ph < m_H), m_run && (m_ph == 0), !m_pend});
  endtask

  // Called just after a negedge with inputs set; returns just after the next negedge.
  task automatic cyc();
    model_step();
    started = 1'b1;
    n_cyc++;
    @(negedge clock);
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic offer(int d, int h, int m);
    bit acc;
    bit done;
    done = 1'b0;
    cfg_div = W'(d); cfg_high = W'(h); cfg_mode = 2'(m); cfg_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      acc = !m_pend && !reset;
      cyc();
      if (acc) begin
        done = 1'b1;
        $display("cycle %0d: cfg transfer div=%0d high=%0d mode=%0d", n_cyc, d, h, m);
      end
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL offer_timeout: accepted=%0d required=1", done);
    end
  endtask

  task automatic wait_phase(int p);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_run && m_ph == p) hit = 1'b1;
      else cyc();
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL phase_wait: reached=%0d required phase %0d", hit, p);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        if ({out_clk, tick, cfg_ready} !== mon_e) begin
          n_err++;
          $display("FAIL outputs t=%0t: {out_clk,tick,cfg_ready} got %b required %b",
                   $time, {out_clk, tick, cfg_ready}, mon_e);
        end
      end else if (started) begin
        n_err++;
        $display("FAIL scoreboard_underflow t=%0t: got empty queue required entry", $time);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_div = '0; cfg_high = '0; cfg_mode = '0;
`ifdef CLKDIV_SYNC_EN
    sync_in = 1'b0;
`endif
    @(negedge clock);
    run(2);
    reset = 1'b0;
    run(2);
    // Defaults: 10 high / 10 low, tick every 20
    enable = 1'b1;
    run(45);

    // Duty 3/4 from idle
    enable = 1'b0; run(2);
    offer(7, 3, 1); run(1);
    enable = 1'b1; run(21);

    // Pulse, div=4
    enable = 1'b0; run(1);
    offer(4, 0, 2);
    enable = 1'b1; run(12);

    // Clamping cases
    enable = 1'b0; run(1); offer(0, 0, 0); enable = 1'b1; run(8);
    enable = 1'b0; run(1); offer(6, 9, 1); enable = 1'b1; run(12);
    enable = 1'b0; run(1); offer(6, 0, 1); enable = 1'b1; run(12);
    enable = 1'b0; run(1); offer(5, 0, 3); enable = 1'b1; run(10);

    // Mid-period update at D=20, plus a second offer held off until the wrap
    reset = 1'b1; run(1); reset = 1'b0;
    enable = 1'b1; run(1);
    wait_phase(5);
    offer(4, 0, 0);
    offer(5, 2, 1);
    run(30);

    // Offer accepted on the wrap edge applies at the following wrap
    wait_phase(4);
    offer(8, 0, 2);
    run(20);

    // Enable dropped at C=3
    wait_phase(3);
    enable = 1'b0; run(2);
    enable = 1'b1; run(10);

    // Reset while pending discards the config
    wait_phase(2);
    offer(12, 0, 0);
    reset = 1'b1; run(1); reset = 1'b0;
    run(45);

`ifdef CLKDIV_SYNC_EN
    offer(10, 0, 0);
    run(20);
    wait_phase(6);
    sync_in = 1'b1; run(1); sync_in = 1'b0;
    run(25);
    enable = 1'b0; sync_in = 1'b1; run(3); sync_in = 1'b0; enable = 1'b1;
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit acc;
      reset  = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 19) != 0);
`ifdef CLKDIV_SYNC_EN
      sync_in = ($urandom_range(0, 39) == 0);
`endif
      if (!cfg_valid && $urandom_range(0, 9) == 0) begin
        cfg_div   = W'($urandom_range(0, 12));
        cfg_high  = W'($urandom_range(0, 14));
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_valid = 1'b1;
      end
      acc = cfg_valid && !m_pend && !reset;
      cyc();
      if (acc) begin
        cfg_valid = 1'b0;
        $display("cycle %0d: cfg transfer div=%0d high=%0d mode=%0d",
                 n_cyc, cfg_div, cfg_high, cfg_mode);
      end
    end
    reset = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
`ifdef CLKDIV_SYNC_EN
    sync_in = 1'b0;
`endif
    run(2);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider generating a divided clock-enable waveform and a period tick from the system clock. It generalises the team's fixed-limit counter/comparator/toggle divider: the counter is parametrised in width and is reloaded from a config shadow register via a valid/ready handshake. Configuration changes take effect only at period boundaries, so the output never glitches. Three waveform modes are supported: square, programmable duty, and single-cycle pulse. It sits between the register interface and any logic needing a slow, software-tunable enable or strobe.

## Interface
- WIDTH, 30, width of counter, cfg_div and cfg_high
- DEFAULT_DIV, 20, active period in cycles after reset (must be >= 2)
- DEFAULT_MODE, 0, active mode after reset
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  run divider; low holds it idle
- cfg_div  in  WIDTH  requested period D in clock cycles
- cfg_high  in  WIDTH  requested high time, used in duty mode only
- cfg_mode  in  2  00 square, 01 duty, 10 pulse, 11 reserved (behaves as 00)
- cfg_valid  in  1  config offer
- cfg_ready  out  1  shadow register free
- out_clk  out  1  divided waveform, registered
- tick  out  1  one-cycle strobe on first cycle of each period, registered

## Operation
- Reset: count C=0, running=0, active D=DEFAULT_DIV, mode=DEFAULT_MODE, active H derived from them, pending=0, out_clk=0, tick=0, cfg_ready=1.
- Clock source: reset is synchronous, active-high; clock is `clock`.
- Handshake: cfg_ready = !pending. Transfer happens when cfg_valid && cfg_ready. On transfer, cfg_div, cfg_high and cfg_mode are captured into the shadow register and pending is set.
- Applying config when idle (running=0): the pending config becomes active on the next edge and pending clears. cfg_ready is low for exactly 1 cycle.
- Applying config when running: the pending config becomes active on the edge where C wraps to 0, so the whole new period uses the new config.
- A transfer on the same edge as a wrap is too late for that wrap and applies at the following one.
- Clamping, applied when config becomes active:
  - D = max(cfg_div, 2).
  - square: H = D>>1 (odd D gives a shorter high phase, e.g. D=5 gives 2 high, 3 low).
  - duty: H = min(max(cfg_high, 1), D-1).
  - pulse: H = 1.
- Running: C counts 0..D-1 and wraps. out_clk=1 exactly in cycles where C<H. tick=1 exactly in cycles where C==0.
- Idle: while enable=0, running=0, C=0, out_clk=0, tick=0.
- Counter arithmetic: C is WIDTH bits. It never exceeds D-1, so no overflow handling is needed.
- Enable deasserted mid-period: the next cycle is idle with C=0 and out_clk=0. A pending config is applied on that edge.
- Reset mid-operation: every register returns to its reset value and any pending config is discarded.

## Timing
- Start-up latency: enable sampled high at edge N (previously idle) gives C=0, tick=1 and out_clk=1 in the cycle after edge N. out_clk and tick are driven from next-state logic, so they are aligned with C.
- Output period is D cycles. out_clk and tick are glitch-free because both are registered.
- Config latency: from transfer to effect is at most D cycles when running, and exactly 1 cycle when idle.
- Back-to-back offers: a second cfg_valid is stalled (cfg_ready=0) until the first config is applied.
- Throughput: at most one config per period.

## Configuration
- `CLKDIV_SYNC_EN` defined:
  - Adds input port `sync_in` (1 bit).
  - If running and sync_in=1 at an edge, the next C=0 (phase restart): tick=1 and out_clk=1 in that cycle.
  - Any pending config is applied at that restart.
  - sync_in is ignored while idle.
  - sync_in has priority over the normal increment. It has no effect on the edge where enable goes low.
- `CLKDIV_SYNC_EN` undefined: the port is absent and phase is set only by enable and reset.

## Test plan
- Reset defaults: reset, then enable=1 -> out_clk pattern is 10 high / 10 low; tick every 20 cycles; first tick and out_clk=1 in the cycle after enable sampled.
- Duty and pulse modes:
  - Idle, offer div=7, high=3, mode=01, then enable -> repeating 3 high / 4 low; cfg_ready low for 1 cycle after transfer.
  - mode=10, div=4 -> out_clk equals tick, 1 high / 3 low.
- Clamping:
  - div=0, mode=00 -> period 2, 1 high / 1 low.
  - div=6, high=9, mode=01 -> 5 high / 1 low.
  - div=6, high=0, mode=01 -> 1 high / 5 low.
- Mid-period update: running at D=20, offer div=4 when C=5 -> current period completes all 20 cycles, then 2 high / 2 low; cfg_ready stays 0 from transfer until the wrap; a second offer is held off.
- Boundary cases:
  - Offer accepted on the wrap edge -> applies at the next wrap.
  - enable dropped at C=3 -> next cycle out_clk=0, C=0.
  - reset while pending -> the config is discarded and D=20 resumes.
- With `CLKDIV_SYNC_EN`: D=10 running, pulse sync_in at C=6 -> next cycle tick=1, C=0, then a full 10-cycle period.
